// File: rtl/led_row_rd_sched.sv
// rtl/led_row_rd_sched.sv - block-row read scheduler between pixel FIFO and LED row assembler (optional macro: ROW_TIMEOUT_EN)
module led_row_rd_sched #(
  parameter int PIX_PER_ROW = 40,
  parameter int ROWS        = 36,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic       rd_clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  output logic       pix_we,
  output logic [5:0] pix_idx,
  output logic       row_valid,
  input  logic       row_ready,
  output logic [5:0] row_idx,
  output logic       frame_done,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_PRESENT} state_t;

  localparam logic [5:0] PIX_MAX  = 6'(PIX_PER_ROW);
  localparam logic [5:0] PIX_LAST = 6'(PIX_PER_ROW - 1);
  localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);

  state_t     state;
  state_t     next_state;
  logic [5:0] rd_cnt;
  logic [5:0] wr_cnt;
  logic       issue;
  logic       last_wr;
  logic       xfer;
  logic       tmo;

  // A read goes out whenever the row still needs pixels and the FIFO has one; a restart takes priority
  assign issue   = (state == S_FILL) && !fifo_empty && (rd_cnt < PIX_MAX) && !frame_start;
  assign last_wr = pix_we && (wr_cnt == PIX_LAST);
  assign xfer    = (state == S_PRESENT) && row_ready;
  assign pix_idx = wr_cnt;

`ifdef ROW_TIMEOUT_EN
  localparam logic [9:0] IDLE_LAST = 10'(TIMEOUT_CYC - 1);

  logic [9:0] idle_cnt;

  assign tmo = (state == S_FILL) && fifo_empty && (idle_cnt == IDLE_LAST) && !frame_start;

  // Counts consecutive starved cycles in FILL; any read or leaving FILL starts it over
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if ((state != S_FILL) || frame_start || issue || tmo) begin
      idle_cnt <= '0;
    end else if (fifo_empty) begin
      idle_cnt <= idle_cnt + 10'd1;
    end
  end

  // Sticky abort flag, cleared only by the next frame
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else if (frame_start) begin
      timeout_err <= 1'b0;
    end else if (tmo) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; frame_start restarts the frame from any state
  always_comb begin
    next_state = state;
    if (frame_start) begin
      next_state = S_FILL;
    end else begin
      case (state)
        S_IDLE:    next_state = S_IDLE;
        S_FILL: begin
          if (tmo) begin
            next_state = S_IDLE;
          end else if (issue && (rd_cnt == PIX_LAST)) begin
            next_state = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (last_wr) begin
            next_state = S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (row_ready) begin
            next_state = (row_idx == ROW_LAST) ? S_IDLE : S_FILL;
          end
        end
        default:   next_state = S_IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    row_valid = (state == S_PRESENT);
    busy      = (state != S_IDLE);
  end

  // Read strobe and the write strobe that trails it by the FIFO's one-cycle latency;
  // a write owed to a read that a restart or abort orphans is dropped
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_rd_en <= 1'b0;
      pix_we     <= 1'b0;
    end else begin
      fifo_rd_en <= issue;
      pix_we     <= fifo_rd_en && !frame_start && !tmo;
    end
  end

  // Reads issued in the current row
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
    end else if (frame_start || xfer || tmo) begin
      rd_cnt <= '0;
    end else if (issue) begin
      rd_cnt <= rd_cnt + 6'd1;
    end
  end

  // Slice index of the next assembler write; wraps to 0 after the row's last slice
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
    end else if (frame_start || tmo || last_wr) begin
      wr_cnt <= '0;
    end else if (pix_we) begin
      wr_cnt <= wr_cnt + 6'd1;
    end
  end

  // Block-row position within the frame and end-of-frame pulse
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= xfer && (row_idx == ROW_LAST) && !frame_start;
      if (frame_start || tmo) begin
        row_idx <= '0;
      end else if (xfer) begin
        row_idx <= (row_idx == ROW_LAST) ? 6'd0 : row_idx + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_led_row_rd_sched.sv
// tb/tb_led_row_rd_sched.sv - self-checking bench for led_row_rd_sched
module tb_led_row_rd_sched;

  localparam int PIX    = 40;
  localparam int ROWS_N = 36;
  localparam int TMO    = 16;

  logic       rd_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       fifo_empty = 1'b0;
  logic       row_ready = 1'b0;
  logic       fifo_rd_en;
  logic       pix_we;
  logic [5:0] pix_idx;
  logic       row_valid;
  logic [5:0] row_idx;
  logic       frame_done;
  logic       busy;
  logic       timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  led_row_rd_sched #(
    .PIX_PER_ROW(PIX),
    .ROWS(ROWS_N),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .rd_clk(rd_clk),
    .rst_n(rst_n),
    .frame_start(frame_start),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .pix_we(pix_we),
    .pix_idx(pix_idx),
    .row_valid(row_valid),
    .row_ready(row_ready),
    .row_idx(row_idx),
    .frame_done(frame_done),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic cyc();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic do_reset();
    frame_start = 1'b0;
    fifo_empty  = 1'b0;
    row_ready   = 1'b0;
    rst_n       = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    logic [19:0] obs;
    do_reset();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    repeat (6) cyc();
    #2 rst_n = 1'b0;
    #1;
    obs = {fifo_rd_en, pix_we, row_valid, busy, frame_done, timeout_err, pix_idx, row_idx, 2'b00};
    n_cmp++;
    if (obs !== 20'h0) begin
      n_err++;
      $display("FAIL reset_async outputs got %0h want 0", obs);
    end
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      obs = {fifo_rd_en, pix_we, row_valid, busy, frame_done, timeout_err, pix_idx, row_idx, 2'b00};
      n_cmp++;
      if (obs !== 20'h0) begin
        n_err++;
        $display("FAIL reset_idle cycle %0d outputs got %0h want 0", i, obs);
      end
    end
  endtask

  task automatic test_full_frame();
    int rd = 0;
    int rd_row = 0;
    int wr = 0;
    int vcnt = 0;
    bit done_seen = 0;
    do_reset();
    row_ready   = 1'b1;
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    for (int c = 0; c < 2500 && !done_seen; c++) begin
      cyc();
      if (fifo_rd_en) begin
        rd++;
        rd_row++;
      end
      if (pix_we) begin
        n_cmp++;
        if (pix_idx !== 6'(wr % PIX)) begin
          n_err++;
          $display("FAIL full_pix_idx got %0d want %0d", pix_idx, wr % PIX);
        end
        wr++;
      end
      if (row_valid) begin
        n_cmp++;
        if (row_idx !== 6'(vcnt) || rd_row != PIX) begin
          n_err++;
          $display("FAIL full_row got idx %0d reads %0d want idx %0d reads %0d", row_idx, rd_row, vcnt, PIX);
        end
        vcnt++;
        rd_row = 0;
      end
      if (frame_done) begin
        done_seen = 1;
        n_cmp++;
        if (busy !== 1'b0 || row_idx !== 6'd0) begin
          n_err++;
          $display("FAIL full_done_state got busy %0d row %0d want 0 0", busy, row_idx);
        end
      end
    end
    n_cmp++;
    if (!done_seen || rd != PIX * ROWS_N || wr != PIX * ROWS_N || vcnt != ROWS_N) begin
      n_err++;
      $display("FAIL full_totals got done %0d rd %0d wr %0d rows %0d want 1 %0d %0d %0d",
               done_seen, rd, wr, vcnt, PIX * ROWS_N, PIX * ROWS_N, ROWS_N);
    end
    cyc();
    n_cmp++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL full_after got done %0d busy %0d want 0 0", frame_done, busy);
    end
  endtask

  task automatic test_empty_gap();
    int rd = 0;
    int wr = 0;
    int gap_at = -1;
    bit got_valid = 0;
    do_reset();
    row_ready   = 1'b1;
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    for (int c = 0; c < 300 && !got_valid; c++) begin
      cyc();
      if (fifo_rd_en) rd++;
      if (pix_we) begin
        n_cmp++;
        if (pix_idx !== 6'(wr)) begin
          n_err++;
          $display("FAIL gap_pix_idx got %0d want %0d", pix_idx, wr);
        end
        wr++;
      end
      if (gap_at >= 0 && c > gap_at && c <= gap_at + 5) begin
        n_cmp++;
        if (fifo_rd_en !== 1'b0) begin
          n_err++;
          $display("FAIL gap_rd_low got %0d want 0", fifo_rd_en);
        end
      end
      if (gap_at >= 0 && c == gap_at + 6) begin
        n_cmp++;
        if (fifo_rd_en !== 1'b1) begin
          n_err++;
          $display("FAIL gap_rd_resume got %0d want 1", fifo_rd_en);
        end
      end
      if (rd == 18 && gap_at < 0) gap_at = c;
      fifo_empty = (gap_at >= 0 && c >= gap_at && c < gap_at + 5);
      if (row_valid) got_valid = 1;
    end
    n_cmp++;
    if (!got_valid || rd != PIX || wr != PIX) begin
      n_err++;
      $display("FAIL gap_totals got valid %0d rd %0d wr %0d want 1 %0d %0d", got_valid, rd, wr, PIX, PIX);
    end
  endtask

  task automatic test_backpressure();
    bit got_valid = 0;
    do_reset();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    for (int c = 0; c < 200 && !got_valid; c++) begin
      cyc();
      if (row_valid) got_valid = 1;
    end
    n_cmp++;
    if (!got_valid) begin
      n_err++;
      $display("FAIL bp_valid_timeout got 0 want 1");
    end
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_cmp++;
      if ({row_valid, fifo_rd_en, pix_we, row_idx} !== {3'b100, 6'd0}) begin
        n_err++;
        $display("FAIL bp_hold got %0h want %0h", {row_valid, fifo_rd_en, pix_we, row_idx}, {3'b100, 6'd0});
      end
    end
    row_ready = 1'b1;
    cyc();
    n_cmp++;
    if ({row_valid, frame_done, busy, row_idx} !== {3'b001, 6'd1}) begin
      n_err++;
      $display("FAIL bp_xfer got %0h want %0h", {row_valid, frame_done, busy, row_idx}, {3'b001, 6'd1});
    end
    cyc();
    n_cmp++;
    if (fifo_rd_en !== 1'b1) begin
      n_err++;
      $display("FAIL bp_next_row_rd got %0d want 1", fifo_rd_en);
    end
  endtask

  task automatic test_restart();
    int rd = 0;
    bit hit = 0;
    bit got_we = 0;
    bit saw_done = 0;
    do_reset();
    row_ready   = 1'b1;
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    for (int c = 0; c < 1000 && !hit; c++) begin
      cyc();
      if (fifo_rd_en) rd++;
      if (rd == 3 * PIX + 26) hit = 1;
    end
    n_cmp++;
    if (!hit || row_idx !== 6'd3) begin
      n_err++;
      $display("FAIL rs_reach got hit %0d row %0d want 1 3", hit, row_idx);
    end
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    n_cmp++;
    if ({pix_we, row_valid, fifo_rd_en, frame_done, busy, row_idx} !== {5'b00001, 6'd0}) begin
      n_err++;
      $display("FAIL rs_abort got %0h want %0h", {pix_we, row_valid, fifo_rd_en, frame_done, busy, row_idx},
               {5'b00001, 6'd0});
    end
    for (int c = 0; c < 50 && !got_we; c++) begin
      cyc();
      if (frame_done) saw_done = 1;
      if (pix_we) begin
        got_we = 1;
        n_cmp++;
        if (pix_idx !== 6'd0 || row_idx !== 6'd0) begin
          n_err++;
          $display("FAIL rs_first_we got idx %0d row %0d want 0 0", pix_idx, row_idx);
        end
      end
    end
    n_cmp++;
    if (!got_we || saw_done) begin
      n_err++;
      $display("FAIL rs_resume got we %0d done %0d want 1 0", got_we, saw_done);
    end
  endtask

  task automatic test_restart_at_last_row();
    bit hit = 0;
    do_reset();
    row_ready   = 1'b1;
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    for (int c = 0; c < 2500 && !hit; c++) begin
      cyc();
      if (row_valid && row_idx == 6'(ROWS_N - 1)) hit = 1;
      else row_ready = (row_idx != 6'(ROWS_N - 1));
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL rl_reach got 0 want 1");
    end
    frame_start = 1'b1;
    row_ready   = 1'b1;
    cyc();
    frame_start = 1'b0;
    n_cmp++;
    if ({frame_done, row_valid, busy, row_idx} !== {3'b001, 6'd0}) begin
      n_err++;
      $display("FAIL rl_coincide got %0h want %0h", {frame_done, row_valid, busy, row_idx}, {3'b001, 6'd0});
    end
    cyc();
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL rl_no_done got %0d want 0", frame_done);
    end
  endtask

  task automatic test_random();
    bit m_rd = 0, m_we = 0, m_valid = 0, m_done = 0, m_active = 0;
    int m_widx = 0, m_wcount = 0, m_reads = 0, m_row = 0;
    bit n_rd, n_we, n_valid, n_done, n_active;
    int n_widx, n_wcount, n_reads, n_row;
    bit fs, emp, rdy, xfer, issue;
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      fs  = (!m_active && $urandom_range(0, 7) == 0) || ($urandom_range(0, 599) == 0);
      emp = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      frame_start = fs;
      fifo_empty  = emp;
      row_ready   = rdy;
      if (fs) begin
        n_rd = 0; n_we = 0; n_widx = 0; n_wcount = 0; n_reads = 0;
        n_valid = 0; n_done = 0; n_row = 0; n_active = 1;
      end else begin
        xfer     = m_valid && rdy;
        issue    = m_active && !m_valid && (m_reads < PIX) && !emp;
        n_we     = m_rd;
        n_widx   = m_wcount;
        n_wcount = xfer ? 0 : m_wcount + int'(m_rd);
        n_valid  = m_valid ? !rdy : (m_we && m_widx == PIX - 1);
        n_rd     = issue;
        n_reads  = xfer ? 0 : m_reads + int'(issue);
        n_done   = xfer && (m_row == ROWS_N - 1);
        n_row    = xfer ? ((m_row == ROWS_N - 1) ? 0 : m_row + 1) : m_row;
        n_active = m_active && !n_done;
      end
      cyc();
      n_cmp++;
      if ({fifo_rd_en, pix_we, row_valid, frame_done, busy, timeout_err, row_idx} !==
          {n_rd, n_we, n_valid, n_done, n_active, 1'b0, 6'(n_row)}) begin
        n_err++;
        $display("FAIL rand_cycle %0d got %0h want %0h", c,
                 {fifo_rd_en, pix_we, row_valid, frame_done, busy, timeout_err, row_idx},
                 {n_rd, n_we, n_valid, n_done, n_active, 1'b0, 6'(n_row)});
      end
      if (n_we) begin
        n_cmp++;
        if (pix_idx !== 6'(n_widx)) begin
          n_err++;
          $display("FAIL rand_pix_idx cycle %0d got %0d want %0d", c, pix_idx, n_widx);
        end
      end
      m_rd = n_rd; m_we = n_we; m_widx = n_widx; m_wcount = n_wcount; m_reads = n_reads;
      m_valid = n_valid; m_done = n_done; m_row = n_row; m_active = n_active;
    end
    frame_start = 1'b0;
  endtask

`ifdef ROW_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    repeat (10) cyc();
    fifo_empty = 1'b1;
    for (int k = 1; k <= TMO; k++) begin
      cyc();
      n_cmp++;
      if (k < TMO && {timeout_err, busy} !== 2'b01) begin
        n_err++;
        $display("FAIL to_early step %0d got %0b want 01", k, {timeout_err, busy});
      end else if (k == TMO && {timeout_err, busy, row_idx} !== {2'b10, 6'd0}) begin
        n_err++;
        $display("FAIL to_fire got %0h want %0h", {timeout_err, busy, row_idx}, {2'b10, 6'd0});
      end
    end
    repeat (3) cyc();
    n_cmp++;
    if (timeout_err !== 1'b1) begin
      n_err++;
      $display("FAIL to_sticky got %0d want 1", timeout_err);
    end
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    n_cmp++;
    if ({timeout_err, busy} !== 2'b01) begin
      n_err++;
      $display("FAIL to_clear got %0b want 01", {timeout_err, busy});
    end
    fifo_empty = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_empty_gap();
    test_backpressure();
    test_restart();
    test_restart_at_last_row();
    test_random();
`ifdef ROW_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
